// File: rtl/trace_buffer.sv
// Instruction-retire trace capture: circular snapshot buffer of CPU state with
// optional PC-match trigger, post-trigger freeze and a pop-style read port.
module trace_buffer #(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int CYC_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      retire,
    input  logic [15:0]               pc,
    input  logic [7:0]                ir,
    input  logic [7:0]                reg_a,
    input  logic [7:0]                reg_f,
    input  logic [7:0]                reg_b,
    input  logic [7:0]                reg_c,
    input  logic [7:0]                reg_d,
    input  logic [7:0]                reg_e,
    input  logic [7:0]                reg_h,
    input  logic [7:0]                reg_l,
    input  logic                      arm,
    input  logic                      trig_en,
    input  logic [15:0]               trig_pc,
    input  logic                      rd_en,
    output logic [CYC_W+87:0]         rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic [1:0]                state,
    output logic                      overflow,
    output logic                      triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = CYC_W + 88;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARMED     = 2'd1;
    localparam logic [1:0] S_TRIGGERED = 2'd2;
    localparam logic [1:0] S_FROZEN    = 2'd3;

    localparam logic [AW:0]      CNT_ONE  = 1;
    localparam logic [AW:0]      CNT_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [AW-1:0]    POST_CNT = POST_TRIG[AW-1:0];
    localparam logic [CYC_W-1:0] CYC_ONE  = 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    post_cnt;
    logic [CYC_W-1:0] cyc;
    logic [W-1:0]     entry;
    logic             capturing;
    logic             do_wr;
    logic             do_rd;
    logic             full;
    logic             hit;

    // arm wins over everything else in its cycle: no capture, no pop.
    assign capturing = (state == S_ARMED) || (state == S_TRIGGERED);
    assign do_wr     = retire && capturing && !arm;
    assign do_rd     = rd_en && (count != '0) && !arm;
    assign full      = (count == CNT_FULL);
    assign hit       = (state == S_ARMED) && trig_en && retire && (pc == trig_pc);
    assign entry     = {cyc, pc, ir, reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + CYC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            post_cnt  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end
            if (arm) begin
                state     <= S_ARMED;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                triggered <= 1'b0;
                post_cnt  <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                // A write into a full buffer evicts the oldest entry, same as a pop.
                if (do_rd || (do_wr && full)) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (do_wr && full && !do_rd) begin
                    overflow <= 1'b1;
                end
                if (do_wr && !do_rd && !full) begin
                    count <= count + CNT_ONE;
                end else if (do_rd && !do_wr) begin
                    count <= count - CNT_ONE;
                end

                case (state)
                    S_ARMED: begin
                        if (hit) begin
                            triggered <= 1'b1;
                            if (POST_TRIG == 0) begin
                                state <= S_FROZEN;
                            end else begin
                                state    <= S_TRIGGERED;
                                post_cnt <= POST_CNT;
                            end
                        end
                    end
                    S_TRIGGERED: begin
                        if (retire) begin
                            post_cnt <= post_cnt - PTR_ONE;
                            if (post_cnt == PTR_ONE) begin
                                state <= S_FROZEN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trace_buffer;
    localparam int DEPTH     = 4;
    localparam int POST_TRIG = 2;
    localparam int CYC_W     = 16;
    localparam int W         = CYC_W + 88;

    logic          clk = 1'b0;
    logic          rst;
    logic          retire;
    logic [15:0]   pc;
    logic [7:0]    ir;
    logic [7:0]    reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
    logic          arm;
    logic          trig_en;
    logic [15:0]   trig_pc;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [2:0]    count;
    logic [1:0]    state;
    logic          overflow;
    logic          triggered;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .ir(ir),
        .reg_a(reg_a), .reg_f(reg_f), .reg_b(reg_b), .reg_c(reg_c),
        .reg_d(reg_d), .reg_e(reg_e), .reg_h(reg_h), .reg_l(reg_l),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .state(state),
        .overflow(overflow), .triggered(triggered)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a plain queue of snapshots.
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     m_data;
    logic [W-1:0]     m_entry;
    logic [CYC_W-1:0] m_cyc;
    logic             m_valid, m_ov, m_trg;
    logic             live = 1'b0;
    int               m_state, m_left;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_state = 0;
            m_left  = 0;
            m_cyc   = '0;
            m_ov    = 1'b0;
            m_trg   = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            live    = 1'b1;
        end else begin
            m_entry = {m_cyc, pc, ir, reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l};
            m_cyc   = m_cyc + 16'd1;
            m_valid = 1'b0;
            if (arm) begin
                exp_q.delete();
                m_ov    = 1'b0;
                m_trg   = 1'b0;
                m_left  = 0;
                m_state = 1;
            end else begin
                if (rd_en && exp_q.size() > 0) begin
                    m_data  = exp_q.pop_front();
                    m_valid = 1'b1;
                end
                if (retire && (m_state == 1 || m_state == 2)) begin
                    if (exp_q.size() == DEPTH) begin
                        void'(exp_q.pop_front());
                        m_ov = 1'b1;
                    end
                    exp_q.push_back(m_entry);
                    if (m_state == 1 && trig_en && pc == trig_pc) begin
                        m_trg   = 1'b1;
                        m_left  = POST_TRIG;
                        m_state = (POST_TRIG == 0) ? 3 : 2;
                    end else if (m_state == 2) begin
                        m_left--;
                        if (m_left == 0) m_state = 3;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("rd_valid", W'(rd_valid), W'(m_valid));
            check("rd_data", rd_data, m_data);
            check("count", W'(count), W'(exp_q.size()));
            check("state", W'(state), W'(m_state));
            check("overflow", W'(overflow), W'(m_ov));
            check("triggered", W'(triggered), W'(m_trg));
        end
    end

    task automatic drive(input logic r, input logic [15:0] p, input logic [7:0] i,
                         input logic rd, input logic a);
        retire = r;
        pc     = p;
        ir     = i;
        rd_en  = rd;
        arm    = a;
        reg_a = 8'($urandom); reg_f = 8'($urandom); reg_b = 8'($urandom); reg_c = 8'($urandom);
        reg_d = 8'($urandom); reg_e = 8'($urandom); reg_h = 8'($urandom); reg_l = 8'($urandom);
        @(negedge clk);
        retire = 1'b0;
        rd_en  = 1'b0;
        arm    = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 16'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] bpc[3];
        logic [7:0]  bir[3];
        logic [15:0] prev;
        bpc = '{16'h0100, 16'h0101, 16'h0104};
        bir = '{8'h00, 8'h3E, 8'hC3};

        rst = 1'b0; retire = 1'b0; pc = '0; ir = '0; arm = 1'b0; rd_en = 1'b0;
        trig_en = 1'b0; trig_pc = '0;
        {reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l} = '0;

        // reset and idle: retires without arm are not captured
        idle();
        idle();
        check("rst_state", W'(state), W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_rd_data", rd_data, W'(0));
        check("rst_overflow", W'(overflow), W'(0));
        rst = 1'b1;
        for (int k = 0; k < 5; k++) drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0);
        check("idle_state", W'(state), W'(0));
        check("idle_count", W'(count), W'(0));

        // basic capture and read-back
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, bpc[k], bir[k], 1'b0, 1'b0);
        check("basic_count3", W'(count), W'(3));
        prev = '0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
            check("basic_valid", W'(rd_valid), W'(1));
            check("basic_pc", W'(rd_data[87:72]), W'(bpc[k]));
            check("basic_ir", W'(rd_data[71:64]), W'(bir[k]));
            check("basic_stamp_inc", W'(rd_data[103:88] > prev), W'(1));
            prev = rd_data[103:88];
        end
        check("basic_count0", W'(count), W'(0));

        // wrap and overflow
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) drive(1'b1, 16'h0010 + 16'(k), 8'($urandom), 1'b0, 1'b0);
        check("wrap_count", W'(count), W'(4));
        check("wrap_overflow", W'(overflow), W'(1));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
            check("wrap_pc", W'(rd_data[87:72]), W'(16'h0012 + 16'(k)));
        end

        // trigger and freeze
        trig_en = 1'b1; trig_pc = 16'h0150;
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        drive(1'b1, 16'h0148, 8'h01, 1'b0, 1'b0);
        check("trig_armed", W'(state), W'(1));
        drive(1'b1, 16'h0150, 8'h02, 1'b0, 1'b0);
        check("trig_fired", W'(state), W'(2));
        drive(1'b1, 16'h0151, 8'h03, 1'b0, 1'b0);
        check("trig_post1", W'(state), W'(2));
        drive(1'b1, 16'h0152, 8'h04, 1'b0, 1'b0);
        check("trig_frozen", W'(state), W'(3));
        drive(1'b1, 16'h0153, 8'h05, 1'b0, 1'b0);
        check("frozen_count", W'(count), W'(4));
        check("frozen_triggered", W'(triggered), W'(1));
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        check("frozen_oldest", W'(rd_data[87:72]), W'(16'h0148));
        trig_en = 1'b0;

        // simultaneous read and write, full and empty
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h0020 + 16'(k), 8'($urandom), 1'b0, 1'b0);
        drive(1'b1, 16'h0024, 8'h77, 1'b1, 1'b0);
        check("full_rw_count", W'(count), W'(4));
        check("full_rw_overflow", W'(overflow), W'(0));
        check("full_rw_valid", W'(rd_valid), W'(1));
        check("full_rw_pc", W'(rd_data[87:72]), W'(16'h0020));
        for (int k = 0; k < 4; k++) drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        check("drained", W'(count), W'(0));
        drive(1'b1, 16'h0030, 8'h11, 1'b1, 1'b0);
        check("empty_rw_valid", W'(rd_valid), W'(0));
        check("empty_rw_count", W'(count), W'(1));

        // re-arm while triggered, then reset while armed
        trig_en = 1'b1; trig_pc = 16'h0200;
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        drive(1'b1, 16'h01FE, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 16'h01FF, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 16'h0200, 8'h00, 1'b0, 1'b0);
        check("rearm_pre_state", W'(state), W'(2));
        check("rearm_pre_count", W'(count), W'(3));
        drive(1'b1, 16'h0201, 8'h00, 1'b1, 1'b1);
        check("rearm_state", W'(state), W'(1));
        check("rearm_count", W'(count), W'(0));
        check("rearm_triggered", W'(triggered), W'(0));
        check("rearm_overflow", W'(overflow), W'(0));
        check("rearm_valid", W'(rd_valid), W'(0));
        trig_en = 1'b0;
        drive(1'b1, 16'h0300, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        rst = 1'b0;
        idle();
        check("rst2_state", W'(state), W'(0));
        check("rst2_count", W'(count), W'(0));
        check("rst2_rd_data", rd_data, W'(0));
        check("rst2_rd_valid", W'(rd_valid), W'(0));
        check("rst2_triggered", W'(triggered), W'(0));
        rst = 1'b1;

        // randomized traffic against the model
        trig_pc = 16'h0040;
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) != 0);
            trig_en = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 1) == 1), 16'($urandom_range(16'h0038, 16'h0048)),
                  8'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0));
        end
        rst = 1'b1;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
